// File: rtl/tx_prbs31_generator_if.sv
`default_nettype none
// tx_prbs31_generator_if: control and data bundle for the PRBS31 transmit source.
// Revision: 1.0
interface tx_prbs31_generator_if #(
  parameter int PERIOD_W = 16
);
  logic                enable;
  logic                seed_load;
  logic [30:0]         seed;
  logic                inject_single;
  logic [PERIOD_W-1:0] inject_period;
  logic [31:0]         DataOut;
  logic                data_valid;
  logic [47:0]         word_count;
  logic [31:0]         injected_count;

  modport master (
    output enable, seed_load, seed, inject_single, inject_period,
    input  DataOut, data_valid, word_count, injected_count
  );

  modport slave (
    input  enable, seed_load, seed, inject_single, inject_period,
    output DataOut, data_valid, word_count, injected_count
  );
endinterface
`default_nettype wire

// File: rtl/tx_prbs31_generator.sv
`default_nettype none
// ============================================================================
// Module   : tx_prbs31_generator
// Brief    : PRBS31 (x^31 + x^28 + 1) word source, 32 bits per enabled clock,
//            MSB = oldest bit. Optional error injection under PRBS_ERR_INJECT_EN.
// Revision : 1.0
// ============================================================================
module tx_prbs31_generator #(
  parameter logic [30:0] SEED_DEFAULT = 31'h7FFFFFFF,
  parameter int          PERIOD_W     = 16
) (
  input  wire logic            clock,
  input  wire logic            reset,
  tx_prbs31_generator_if.slave bus
);

  typedef struct packed {
    logic [31:0] word;
    logic [30:0] state;
  } step_t;

  // seq[m] holds serial bit n-31+m; the first 31 entries are the state, oldest first.
  function automatic step_t prbs_step(input logic [30:0] s);
    logic [62:0] seq;
    step_t       r;
    seq = '0;
    r   = '0;
    for (int m = 0; m < 31; m++) seq[m] = s[30-m];
    for (int m = 31; m < 63; m++) seq[m] = seq[m-31] ^ seq[m-28];
    for (int k = 0; k < 32; k++) r.word[31-k] = seq[31+k];
    for (int j = 0; j < 31; j++) r.state[30-j] = seq[32+j];
    return r;
  endfunction

  logic [30:0] r_state;
  logic [31:0] r_data;
  logic        r_valid;
  logic [47:0] r_word_cnt;

  step_t       w_step;
  logic [30:0] w_seed_eff;
  logic        w_emit;
  logic        w_flip;

  assign w_step     = prbs_step(r_state);
  assign w_seed_eff = (bus.seed == 31'd0) ? SEED_DEFAULT : bus.seed;
  assign w_emit     = !bus.seed_load && bus.enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= SEED_DEFAULT;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_word_cnt <= '0;
    end else if (bus.seed_load) begin
      r_state <= w_seed_eff;
      r_valid <= 1'b0;
    end else if (bus.enable) begin
      r_state    <= w_step.state;
      r_data     <= w_step.word ^ {31'd0, w_flip};
      r_valid    <= 1'b1;
      r_word_cnt <= r_word_cnt + 48'd1;
    end else begin
      r_valid <= 1'b0;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic                r_pending;
  logic [PERIOD_W-1:0] r_period_q;
  logic [PERIOD_W-1:0] r_period_cnt;
  logic [31:0]         r_inj_cnt;

  logic                w_period_chg;
  logic [PERIOD_W-1:0] w_cnt_base;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic                w_period_hit;

  // A changed period value restarts counting with the current word as word 1.
  assign w_period_chg = (bus.inject_period != r_period_q);
  assign w_cnt_base   = w_period_chg ? '0 : r_period_cnt;
  assign w_cnt_inc    = w_cnt_base + PERIOD_W'(1);
  assign w_period_hit = (bus.inject_period != '0) && (w_cnt_inc == bus.inject_period);
  assign w_flip       = w_emit && (r_pending || w_period_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending    <= 1'b0;
      r_period_q   <= '0;
      r_period_cnt <= '0;
      r_inj_cnt    <= '0;
    end else begin
      r_period_q <= bus.inject_period;
      if (w_emit) begin
        r_pending    <= bus.inject_single;
        r_period_cnt <= w_period_hit ? '0 : w_cnt_inc;
        if (w_flip && (r_inj_cnt != 32'hFFFFFFFF)) begin
          r_inj_cnt <= r_inj_cnt + 32'd1;
        end
      end else begin
        r_pending    <= r_pending | bus.inject_single;
        r_period_cnt <= w_cnt_base;
      end
    end
  end

  assign bus.injected_count = r_inj_cnt;
`else
  logic w_unused_inject;
  assign w_unused_inject    = bus.inject_single ^ (^bus.inject_period);
  assign w_flip             = 1'b0;
  assign bus.injected_count = '0;
`endif

  assign bus.DataOut    = r_data;
  assign bus.data_valid = r_valid;
  assign bus.word_count = r_word_cnt;

endmodule
`default_nettype wire
